inst_queue: RTL and testbench

Instruction fetch queue between the fetch stage and the decode stage. Accepts {pc4, instruction} pairs produced by fetch each cycle. Holds them in a small circular FIFO and presents them to decode under a valid/ready handshake. Decouples decode stalls from fetch and discards all queued, wrong-path instructions on a redirect (branch, jump or jr/jalr taken).

---
 rtl/inst_queue.sv | 102 ++++++++++
 tb/tb_inst_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO of {pc4, inst} between fetch and decode.
// Optional macro IQ_BYPASS_EN: an empty queue forwards in_* straight to out_* in the same cycle.
module inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_pc4,
  input  logic [W-1:0]             in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_pc4,
  output logic [W-1:0]             out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [W-1:0] pc4;
    logic [W-1:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          byp;
  logic          push;
  logic          pop;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef IQ_BYPASS_EN
  assign byp = empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  // in_ready depends only on occupancy, never on out_ready
  assign in_ready  = !full;
  assign out_valid = !empty || byp;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // A bypassed pair that decode takes is never stored; one it refuses is stored normally
  assign do_push = push && !(byp && out_ready);
  assign do_pop  = pop && !byp;

  always_comb begin
    head = '0;
    if (byp) begin
      head.pc4  = in_pc4;
      head.inst = in_inst;
    end else if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign out_pc4  = head.pc4;
  assign out_inst = head.inst;

  // Pointers and occupancy; flush overrides any push or pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers move
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{pc4: in_pc4, inst: in_inst};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: vector table for fill/full/drain plus hand sequences, with a queue
// model as scoreboard for handshake and head data.
module tb_inst_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc4;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc4;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [$];

  inst_queue #(.DEPTH(4), .W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc4    (in_pc4),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc4   (out_pc4),
    .out_inst  (out_inst),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check comb outputs against the model, advance model, check count
  task automatic cycle(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
    int          n;
    logic        byp;
    logic        exp_valid;
    logic        exp_ready;
    logic [63:0] exp_head;
    flush = fl; in_valid = iv; in_pc4 = pc; in_inst = ins; out_ready = ordy;
    @(negedge clk);
    n   = model.size();
    byp = 1'b0;
`ifdef IQ_BYPASS_EN
    byp = (n == 0) && iv && !fl;
`endif
    exp_ready = (n != 4);
    exp_valid = (n != 0) || byp;
    if (byp)         exp_head = {pc, ins};
    else if (n != 0) exp_head = model[0];
    else             exp_head = '0;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_head", {out_pc4, out_inst}, exp_head);
    if (fl) begin
      model.delete();
    end else if (byp) begin
      if (!ordy) model.push_back({pc, ins});
    end else begin
      if (exp_valid && ordy) void'(model.pop_front());
      if (iv && exp_ready)   model.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
    chk("count_model", 64'(count), 64'(model.size()));
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        ordy;
    int          cnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // fill to full, hold 0x20080005 while full, pop+push collision, then drain
    vecs = '{
      '{1'b0, 1'b1, 32'h4,  32'h20080001, 1'b0, 1},
      '{1'b0, 1'b1, 32'h8,  32'h20080002, 1'b0, 2},
      '{1'b0, 1'b1, 32'hC,  32'h20080003, 1'b0, 3},
      '{1'b0, 1'b1, 32'h10, 32'h20080004, 1'b0, 4},
      '{1'b0, 1'b1, 32'h14, 32'h20080005, 1'b0, 4},
      '{1'b0, 1'b1, 32'h14, 32'h20080005, 1'b1, 3},
      '{1'b0, 1'b1, 32'h14, 32'h20080005, 1'b0, 4},
      '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 3},
      '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 2},
      '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1},
      '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 0},
      '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 0}
    };

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc4 = '0; in_inst = '0; out_ready = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_pc4", 64'(out_pc4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].fl, vecs[i].iv, vecs[i].pc4, vecs[i].inst, vecs[i].ordy);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
    end

    // steady push+pop at count 2 across pointer wrap
    cycle(1'b0, 1'b1, 32'h100, 32'h24000000, 1'b0);
    cycle(1'b0, 1'b1, 32'h104, 32'h24000001, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 32'h108 + 32'(4 * k), 32'h24000002 + 32'(k), 1'b1);
      chk("stream_count", 64'(count), 64'd2);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("stream_drained", 64'(count), 64'd0);

    // flush with three queued and a push in the flush cycle
    cycle(1'b0, 1'b1, 32'h200, 32'h01000001, 1'b0);
    cycle(1'b0, 1'b1, 32'h204, 32'h01000002, 1'b0);
    cycle(1'b0, 1'b1, 32'h208, 32'h01000003, 1'b0);
    cycle(1'b1, 1'b1, 32'h20C, 32'hDEADBEEF, 1'b1);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, 1'b1, 32'h44, 32'h08000010, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("post_flush_head", 64'(out_inst), 64'h08000010);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // empty queue, word offered with decode ready
    cycle(1'b0, 1'b1, 32'h80, 32'h1000FFFF, 1'b1);
`ifdef IQ_BYPASS_EN
    chk("bypass_count", 64'(count), 64'd0);
`else
    chk("bypass_count", 64'(count), 64'd1);
`endif
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // asynchronous reset mid-cycle with three entries queued
    cycle(1'b0, 1'b1, 32'h300, 32'h0A000001, 1'b0);
    cycle(1'b0, 1'b1, 32'h304, 32'h0A000002, 1'b0);
    cycle(1'b0, 1'b1, 32'h308, 32'h0A000003, 1'b0);
    in_valid = 1'b0;
    chk("pre_reset_count", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out_inst", 64'(out_inst), 64'd0);
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
